axis_pkt_gen: RTL and testbench
===============================

AXIS_PKT_GEN -- requirements
Module: axis_pkt_gen

Interface
REQ-001 Parameter DATA_WIDTH, 64, tdata width in bits; a multiple of 8; tkeep width is DATA_WIDTH/8.
REQ-002 Parameter DEPTH, 16, beat buffer entries; a power of 2, at least 2.
REQ-003 Parameter CNT_WIDTH, 16, width of NUM_REPS, PKT_COUNT and REP_COUNT.
REQ-004 Parameter GAP_WIDTH, 8, width of GAP.
REQ-005 CLK  in  1  single clock; all logic on rising edge.
REQ-006 ARESET  in  1  reset, synchronous, active-high.
REQ-007 LOAD_VALID/LOAD_READY  in/out  1/1  beat-load handshake.
REQ-008 LOAD_DATA/LOAD_KEEP/LOAD_LAST  in  DATA_WIDTH/DATA_WIDTH/8/1  beat to store.
REQ-009 CLEAR  in  1  empties the buffer; honoured in IDLE only.
REQ-010 START  in  1  begins playback; honoured in IDLE only.
REQ-011 STOP  in  1  ends playback at the next packet boundary.
REQ-012 NUM_REPS  in  CNT_WIDTH  buffer passes per run; 0 means continuous; sampled at START.
REQ-013 GAP  in  GAP_WIDTH  idle cycles after each tlast beat; sampled at START.
REQ-014 M_AXIS_tdata/tkeep/tlast/tvalid  out  DATA_WIDTH/DATA_WIDTH/8/1/1  AXI-Stream master.
REQ-015 M_AXIS_tready  in  1  downstream ready.
REQ-016 BUSY  out  1  high in SEND or GAP; DONE  out  1  one-cycle pulse at end of run.
REQ-017 PKT_COUNT/REP_COUNT  out  CNT_WIDTH  tlast handshakes / completed passes in the current run.

Function
REQ-018 Buffer: register array of DEPTH entries; wr_ptr is $clog2(DEPTH)+1 bits.
REQ-019 LOAD_READY = (state==IDLE) && (wr_ptr<DEPTH) && !START.
REQ-020 A load handshake writes entry[wr_ptr] and increments wr_ptr; LOAD_VALID when full is ignored, no overwrite.
REQ-021 CLEAR in IDLE sets wr_ptr=0; CLEAR and a load handshake in the same cycle: CLEAR wins, the beat is dropped.
REQ-022 FSM states IDLE, SEND, GAP.
REQ-023 IDLE->SEND on START when wr_ptr!=0: rd_ptr=0, counters cleared, NUM_REPS/GAP latched, beat 0 loaded into the output register.
REQ-024 START with wr_ptr==0 is ignored and raises DONE for one cycle.
REQ-025 Latency: START sampled at edge N gives tvalid=1 after edge N, carrying beat 0.
REQ-026 tvalid, once high, stays high and tdata/tkeep/tlast stay stable until tvalid&&tready; tvalid never depends combinationally on tready.
REQ-027 The last buffered beat (rd_ptr==wr_ptr-1) is driven with tlast=1 regardless of its stored LOAD_LAST.
REQ-028 On handshake: a non-tlast beat presents the next beat in the next cycle, so back-to-back throughput is 1 beat/cycle.
REQ-029 On handshake of a tlast beat: PKT_COUNT+1, rd_ptr advances; at end of buffer rd_ptr wraps to 0 and REP_COUNT+1.
REQ-030 After a tlast handshake: GAP>0 enters GAP with tvalid=0 for exactly GAP cycles, then SEND; GAP==0 stays in SEND.
REQ-031 Run ends when REP_COUNT reaches a latched NUM_REPS!=0, or on a tlast handshake with the stop flag set; the FSM enters IDLE, tvalid=0, DONE pulses one cycle, any pending gap is skipped.
REQ-032 STOP sets a sticky stop flag while BUSY; STOP during GAP ends the run at once.
REQ-033 Counters wrap modulo 2^CNT_WIDTH.
REQ-034 START/STOP/CLEAR outside their valid states have no effect.

Reset
REQ-035 ARESET high at an edge forces IDLE, wr_ptr=0, rd_ptr=0, tvalid=0, tlast=0, tdata=0, tkeep=0, BUSY=0, DONE=0, counters=0, stop flag=0, LOAD_READY=0 while asserted.
REQ-036 Reset mid-packet aborts immediately; buffer contents are don't-care and logically empty.

Verification
REQ-037 Load 64'hc4c0c02ca553e16f/ff/0, 64'h0000007447c0887a/ff/0, 64'h0100000100030000/ff/0, 64'h5073930200000000/0f/1; START, NUM_REPS=1, tready=1 -> 4 consecutive beats, tlast only on beat 4, PKT_COUNT=1, DONE pulse, BUSY=0.
REQ-038 Same load, tready toggles 1010... -> identical beat sequence, each beat held stable while tready=0.
REQ-039 Same load, NUM_REPS=3, GAP=5, tready=1 -> 3 packets with exactly 5 idle cycles between them, REP_COUNT=3.
REQ-040 NUM_REPS=0, STOP asserted mid-second packet -> that packet completes with tlast, then IDLE and DONE, PKT_COUNT=2.
REQ-041 Load DEPTH+1 beats -> beat DEPTH+1 rejected (LOAD_READY=0); CLEAR then START -> DONE pulse and no tvalid.
REQ-042 ARESET during beat 2 -> tvalid=0 next cycle; START without reload -> no output.

Source files
------------

// File: rtl/axis_pkt_gen.sv
// AXI-Stream packet generator: beats are loaded into a small register buffer
// and replayed as packets, with optional repetitions and inter-packet gaps.
module axis_pkt_gen #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 8
) (
  input  logic                    CLK,
  input  logic                    ARESET,
  input  logic                    LOAD_VALID,
  output logic                    LOAD_READY,
  input  logic [DATA_WIDTH-1:0]   LOAD_DATA,
  input  logic [DATA_WIDTH/8-1:0] LOAD_KEEP,
  input  logic                    LOAD_LAST,
  input  logic                    CLEAR,
  input  logic                    START,
  input  logic                    STOP,
  input  logic [CNT_WIDTH-1:0]    NUM_REPS,
  input  logic [GAP_WIDTH-1:0]    GAP,
  output logic [DATA_WIDTH-1:0]   M_AXIS_tdata,
  output logic [DATA_WIDTH/8-1:0] M_AXIS_tkeep,
  output logic                    M_AXIS_tlast,
  output logic                    M_AXIS_tvalid,
  input  logic                    M_AXIS_tready,
  output logic                    BUSY,
  output logic                    DONE,
  output logic [CNT_WIDTH-1:0]    PKT_COUNT,
  output logic [CNT_WIDTH-1:0]    REP_COUNT
);

  localparam int unsigned KW = DATA_WIDTH / 8;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          wr_q, wr_d;
  logic [AW-1:0]          rd_q, rd_d;
  logic                   tvalid_q, tvalid_d;
  logic                   tlast_q, tlast_d;
  logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
  logic [KW-1:0]          tkeep_q, tkeep_d;
  logic [CNT_WIDTH-1:0]   pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0]   rep_q, rep_d;
  logic [CNT_WIDTH-1:0]   reps_q, reps_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d;
  logic [GAP_WIDTH-1:0]   gcnt_q, gcnt_d;
  logic                   stop_q, stop_d;
  logic                   done_q, done_d;

  logic [DATA_WIDTH-1:0]  mem_data_q [DEPTH];
  logic [KW-1:0]          mem_keep_q [DEPTH];
  logic [DEPTH-1:0]       mem_last_q;

  logic                   wr_en;
  logic                   load_out;
  logic [AW-1:0]          nxt_idx;
  logic [PW-1:0]          last_ptr;
  logic                   rd_at_end;
  logic [CNT_WIDTH-1:0]   rep_inc;

  assign last_ptr   = wr_q - PW'(1);
  assign rd_at_end  = ({1'b0, rd_q} == last_ptr);
  assign rep_inc    = rep_q + CNT_WIDTH'(1);
  assign LOAD_READY = (state_q == S_IDLE) && (wr_q < PW'(DEPTH)) && !START && !ARESET;

  assign M_AXIS_tdata  = tdata_q;
  assign M_AXIS_tkeep  = tkeep_q;
  assign M_AXIS_tlast  = tlast_q;
  assign M_AXIS_tvalid = tvalid_q;
  assign BUSY          = (state_q != S_IDLE);
  assign DONE          = done_q;
  assign PKT_COUNT     = pkt_q;
  assign REP_COUNT     = rep_q;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_data_q[wr_q[AW-1:0]] <= LOAD_DATA;
      mem_keep_q[wr_q[AW-1:0]] <= LOAD_KEEP;
      mem_last_q[wr_q[AW-1:0]] <= LOAD_LAST;
    end
  end

  always_ff @(posedge CLK) begin
    if (ARESET) begin
      state_q  <= S_IDLE;
      wr_q     <= '0;
      rd_q     <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      pkt_q    <= '0;
      rep_q    <= '0;
      reps_q   <= '0;
      gap_q    <= '0;
      gcnt_q   <= '0;
      stop_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      pkt_q    <= pkt_d;
      rep_q    <= rep_d;
      reps_q   <= reps_d;
      gap_q    <= gap_d;
      gcnt_q   <= gcnt_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    pkt_d    = pkt_q;
    rep_d    = rep_q;
    reps_d   = reps_q;
    gap_d    = gap_q;
    gcnt_d   = gcnt_q;
    stop_d   = stop_q;
    done_d   = 1'b0;
    wr_en    = 1'b0;
    load_out = 1'b0;
    nxt_idx  = rd_q;

    case (state_q)
      S_IDLE: begin
        if (START && wr_q != '0) begin
          state_d  = S_SEND;
          rd_d     = '0;
          nxt_idx  = '0;
          load_out = 1'b1;
          pkt_d    = '0;
          rep_d    = '0;
          reps_d   = NUM_REPS;
          gap_d    = GAP;
          stop_d   = 1'b0;
        end else begin
          if (START) done_d = 1'b1;
          if (CLEAR) begin
            wr_d = '0;
          end else if (LOAD_VALID && LOAD_READY) begin
            wr_en = 1'b1;
            wr_d  = wr_q + PW'(1);
          end
        end
      end

      S_SEND: begin
        if (STOP) stop_d = 1'b1;
        if (tvalid_q && M_AXIS_tready) begin
          if (!tlast_q) begin
            rd_d     = rd_q + AW'(1);
            nxt_idx  = rd_d;
            load_out = 1'b1;
          end else begin
            pkt_d = pkt_q + CNT_WIDTH'(1);
            rd_d  = rd_at_end ? '0 : rd_q + AW'(1);
            if (rd_at_end) rep_d = rep_inc;
            // A STOP arriving on the tlast handshake itself still ends the run here.
            if ((rd_at_end && reps_q != '0 && rep_inc == reps_q) || stop_q || STOP) begin
              state_d  = S_IDLE;
              tvalid_d = 1'b0;
              stop_d   = 1'b0;
              done_d   = 1'b1;
            end else if (gap_q != '0) begin
              state_d  = S_GAP;
              tvalid_d = 1'b0;
              gcnt_d   = gap_q - GAP_WIDTH'(1);
            end else begin
              nxt_idx  = rd_d;
              load_out = 1'b1;
            end
          end
        end
      end

      S_GAP: begin
        if (STOP || stop_q) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
          done_d  = 1'b1;
        end else if (gcnt_q == '0) begin
          state_d  = S_SEND;
          nxt_idx  = rd_q;
          load_out = 1'b1;
        end else begin
          gcnt_d = gcnt_q - GAP_WIDTH'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load_out) begin
      tvalid_d = 1'b1;
      tdata_d  = mem_data_q[nxt_idx];
      tkeep_d  = mem_keep_q[nxt_idx];
      tlast_d  = mem_last_q[nxt_idx] || ({1'b0, nxt_idx} == last_ptr);
    end
  end

endmodule

// File: tb/tb_axis_pkt_gen.sv
// Self-checking bench for axis_pkt_gen: directed scenarios plus randomized
// load/playback runs compared against a queue-based packet model.
module tb_axis_pkt_gen;

  localparam int DW    = 64;
  localparam int KW    = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 16;
  localparam int GW    = 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          CLK = 1'b0;
  logic          ARESET, LOAD_VALID, LOAD_READY, LOAD_LAST, CLEAR, START, STOP;
  logic [DW-1:0] LOAD_DATA, M_AXIS_tdata;
  logic [KW-1:0] LOAD_KEEP, M_AXIS_tkeep;
  logic [CW-1:0] NUM_REPS, PKT_COUNT, REP_COUNT;
  logic [GW-1:0] GAP;
  logic          M_AXIS_tlast, M_AXIS_tvalid, M_AXIS_tready, BUSY, DONE;

  int tests = 0;
  int fails = 0;
  int load_to = 0;

  beat_t buf_q[$];
  beat_t exp_q[$];
  beat_t cap[$];
  int    cap_cyc[$];

  axis_pkt_gen #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW), .GAP_WIDTH(GW)) dut (
    .CLK(CLK), .ARESET(ARESET),
    .LOAD_VALID(LOAD_VALID), .LOAD_READY(LOAD_READY),
    .LOAD_DATA(LOAD_DATA), .LOAD_KEEP(LOAD_KEEP), .LOAD_LAST(LOAD_LAST),
    .CLEAR(CLEAR), .START(START), .STOP(STOP),
    .NUM_REPS(NUM_REPS), .GAP(GAP),
    .M_AXIS_tdata(M_AXIS_tdata), .M_AXIS_tkeep(M_AXIS_tkeep),
    .M_AXIS_tlast(M_AXIS_tlast), .M_AXIS_tvalid(M_AXIS_tvalid),
    .M_AXIS_tready(M_AXIS_tready),
    .BUSY(BUSY), .DONE(DONE), .PKT_COUNT(PKT_COUNT), .REP_COUNT(REP_COUNT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_buf();
    CLEAR = 1'b1;
    step();
    CLEAR = 1'b0;
    buf_q.delete();
  endtask

  task automatic load(input beat_t b);
    int w = 0;
    LOAD_VALID = 1'b1; LOAD_DATA = b.d; LOAD_KEEP = b.k; LOAD_LAST = b.l;
    while (!LOAD_READY && w < 20) begin step(); w++; end
    if (w >= 20) load_to++;
    else buf_q.push_back(b);
    step();
    LOAD_VALID = 1'b0;
  endtask

  task automatic load_ref();
    beat_t b;
    b = '{d: 64'hc4c0c02ca553e16f, k: 8'hff, l: 1'b0}; load(b);
    b = '{d: 64'h0000007447c0887a, k: 8'hff, l: 1'b0}; load(b);
    b = '{d: 64'h0100000100030000, k: 8'hff, l: 1'b0}; load(b);
    b = '{d: 64'h5073930200000000, k: 8'h0f, l: 1'b1}; load(b);
  endtask

  // Expected stream: every buffer pass, with the final buffered beat forced to tlast.
  function automatic int build_exp(input int passes);
    int n = 0;
    exp_q.delete();
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < buf_q.size(); i++) begin
        beat_t b = buf_q[i];
        b.l = b.l || (i == buf_q.size() - 1);
        if (b.l) n++;
        exp_q.push_back(b);
      end
    return n;
  endfunction

  task automatic start_run(input int reps, input int gap);
    NUM_REPS = CW'(reps); GAP = GW'(gap); START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // mode 0: ready always, 1: ready toggles 1010.., 2: random ready
  task automatic capture(input int mode, input int stop_at, input int max_cyc,
                         output int done_seen, output int unstable);
    beat_t pend_b;
    logic  pend = 1'b0;
    done_seen = 0; unstable = 0;
    cap.delete(); cap_cyc.delete();
    for (int c = 0; c < max_cyc; c++) begin
      STOP = (c == stop_at);
      if (DONE) begin done_seen = 1; break; end
      if (pend && (!M_AXIS_tvalid || {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast} != pend_b))
        unstable++;
      pend = 1'b0;
      case (mode)
        0:       M_AXIS_tready = 1'b1;
        1:       M_AXIS_tready = (c % 2 == 0);
        default: M_AXIS_tready = 1'($urandom_range(0, 1));
      endcase
      if (M_AXIS_tvalid) begin
        if (M_AXIS_tready) begin
          cap.push_back({M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast});
          cap_cyc.push_back(c);
        end else begin
          pend = 1'b1;
          pend_b = {M_AXIS_tdata, M_AXIS_tkeep, M_AXIS_tlast};
        end
      end
      step();
    end
    STOP = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (3) step();
    tests++;
    if (M_AXIS_tvalid !== 1'b0 || M_AXIS_tlast !== 1'b0 || M_AXIS_tdata !== '0 || M_AXIS_tkeep !== '0) begin
      fails++;
      $display("FAIL reset_out: tvalid=%b tlast=%b tdata=%h tkeep=%h, expected all 0",
               M_AXIS_tvalid, M_AXIS_tlast, M_AXIS_tdata, M_AXIS_tkeep);
    end
    tests++;
    if (BUSY !== 1'b0 || DONE !== 1'b0 || PKT_COUNT !== '0 || REP_COUNT !== '0) begin
      fails++;
      $display("FAIL reset_status: busy=%b done=%b pkt=%0d rep=%0d, expected 0 0 0 0",
               BUSY, DONE, PKT_COUNT, REP_COUNT);
    end
    tests++;
    if (LOAD_READY !== 1'b0) begin
      fails++; $display("FAIL reset_ready: load_ready=%b, expected 0", LOAD_READY);
    end
    ARESET = 1'b0;
    #1;
    tests++;
    if (LOAD_READY !== 1'b1) begin
      fails++; $display("FAIL post_reset_ready: load_ready=%b, expected 1", LOAD_READY);
    end
  endtask

  task automatic test_basic();
    int ds, us, npk;
    clear_buf();
    load_ref();
    tests++;
    if (load_to != 0 || buf_q.size() != 4) begin
      fails++; $display("FAIL basic_load: timeouts=%0d stored=%0d, expected 0 4", load_to, buf_q.size());
    end
    npk = build_exp(1);
    start_run(1, 0);
    capture(0, -1, 50, ds, us);
    tests++;
    if (ds != 1 || cap.size() != 4) begin
      fails++; $display("FAIL basic_len: done=%0d beats=%0d, expected 1 4", ds, cap.size());
    end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      tests++;
      if (cap[i] !== exp_q[i] || cap_cyc[i] != i) begin
        fails++;
        $display("FAIL basic_beat%0d: got %h@%0d, expected %h@%0d", i, cap[i], cap_cyc[i], exp_q[i], i);
      end
    end
    tests++;
    if (PKT_COUNT !== CW'(npk) || REP_COUNT !== CW'(1) || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL basic_counts: pkt=%0d rep=%0d busy=%b, expected %0d 1 0", PKT_COUNT, REP_COUNT, BUSY, npk);
    end
    step();
    tests++;
    if (DONE !== 1'b0) begin
      fails++; $display("FAIL basic_done_pulse: done=%b one cycle later, expected 0", DONE);
    end
  endtask

  task automatic test_backpressure();
    int ds, us;
    void'(build_exp(1));
    start_run(1, 0);
    capture(1, -1, 50, ds, us);
    tests++;
    if (ds != 1 || us != 0 || cap.size() != exp_q.size()) begin
      fails++;
      $display("FAIL bp_run: done=%0d unstable=%0d beats=%0d, expected 1 0 %0d", ds, us, cap.size(), exp_q.size());
    end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      tests++;
      if (cap[i] !== exp_q[i]) begin
        fails++; $display("FAIL bp_beat%0d: got %h, expected %h", i, cap[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_gap();
    int ds, us, npk;
    npk = build_exp(3);
    start_run(3, 5);
    capture(0, -1, 100, ds, us);
    tests++;
    if (ds != 1 || cap.size() != exp_q.size()) begin
      fails++; $display("FAIL gap_len: done=%0d beats=%0d, expected 1 %0d", ds, cap.size(), exp_q.size());
    end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      tests++;
      if (cap[i] !== exp_q[i]) begin
        fails++; $display("FAIL gap_beat%0d: got %h, expected %h", i, cap[i], exp_q[i]);
      end
      if (i + 1 < cap.size()) begin
        tests++;
        if (cap_cyc[i+1] - cap_cyc[i] != (exp_q[i].l ? 6 : 1)) begin
          fails++;
          $display("FAIL gap_spacing%0d: got %0d cycles, expected %0d", i, cap_cyc[i+1] - cap_cyc[i], exp_q[i].l ? 6 : 1);
        end
      end
    end
    tests++;
    if (PKT_COUNT !== CW'(npk) || REP_COUNT !== CW'(3)) begin
      fails++; $display("FAIL gap_counts: pkt=%0d rep=%0d, expected %0d 3", PKT_COUNT, REP_COUNT, npk);
    end
  endtask

  task automatic test_stop();
    int ds, us;
    void'(build_exp(2));
    start_run(0, 0);
    capture(0, 5, 100, ds, us);
    tests++;
    if (ds != 1 || cap.size() != 8 || PKT_COUNT !== CW'(2) || BUSY !== 1'b0) begin
      fails++;
      $display("FAIL stop_run: done=%0d beats=%0d pkt=%0d busy=%b, expected 1 8 2 0", ds, cap.size(), PKT_COUNT, BUSY);
    end
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      tests++;
      if (cap[i] !== exp_q[i]) begin
        fails++; $display("FAIL stop_beat%0d: got %h, expected %h", i, cap[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    int ds, us, npk, n, reps, gap, bad;
    for (int it = 0; it < 5; it++) begin
      clear_buf();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        beat_t b;
        b.d = {$urandom, $urandom};
        b.k = 8'($urandom);
        b.l = ($urandom_range(0, 3) == 0);
        load(b);
      end
      reps = $urandom_range(1, 3);
      gap  = $urandom_range(0, 3);
      npk  = build_exp(reps);
      start_run(reps, gap);
      capture(2, -1, 2000, ds, us);
      bad = 0;
      for (int i = 0; i < cap.size() && i < exp_q.size(); i++)
        if (cap[i] !== exp_q[i]) bad++;
      tests++;
      if (ds != 1 || us != 0 || bad != 0 || cap.size() != exp_q.size() || load_to != 0) begin
        fails++;
        $display("FAIL rand%0d_stream: done=%0d unstable=%0d wrong=%0d beats=%0d, expected 1 0 0 %0d",
                 it, ds, us, bad, cap.size(), exp_q.size());
      end
      tests++;
      if (PKT_COUNT !== CW'(npk) || REP_COUNT !== CW'(reps)) begin
        fails++;
        $display("FAIL rand%0d_counts: pkt=%0d rep=%0d, expected %0d %0d", it, PKT_COUNT, REP_COUNT, npk, reps);
      end
    end
  endtask

  task automatic test_full();
    int ds, us;
    clear_buf();
    for (int i = 0; i < DEPTH; i++) begin
      beat_t b;
      b.d = {$urandom, $urandom};
      b.k = 8'hff;
      b.l = 1'b0;
      load(b);
    end
    LOAD_VALID = 1'b1; LOAD_DATA = 64'hdeadbeefdeadbeef; LOAD_KEEP = 8'h55; LOAD_LAST = 1'b1;
    tests++;
    if (LOAD_READY !== 1'b0) begin
      fails++; $display("FAIL full_ready: load_ready=%b with %0d beats stored, expected 0", LOAD_READY, DEPTH);
    end
    step();
    LOAD_VALID = 1'b0;
    void'(build_exp(1));
    start_run(1, 0);
    capture(0, -1, 60, ds, us);
    tests++;
    if (ds != 1 || cap.size() != DEPTH || cap[0] !== exp_q[0] || cap[DEPTH-1] !== exp_q[DEPTH-1]) begin
      fails++;
      $display("FAIL full_play: done=%0d beats=%0d first=%h last=%h, expected 1 %0d %h %h",
               ds, cap.size(), cap[0], cap[DEPTH-1], DEPTH, exp_q[0], exp_q[DEPTH-1]);
    end
    clear_buf();
    start_run(1, 0);
    capture(0, -1, 10, ds, us);
    tests++;
    if (ds != 1 || cap.size() != 0) begin
      fails++; $display("FAIL empty_start: done=%0d beats=%0d, expected 1 0", ds, cap.size());
    end
  endtask

  task automatic test_reset_mid();
    int ds, us;
    clear_buf();
    load_ref();
    start_run(1, 0);
    M_AXIS_tready = 1'b1;
    step();
    step();
    tests++;
    if (M_AXIS_tvalid !== 1'b1 || M_AXIS_tdata !== buf_q[2].d) begin
      fails++; $display("FAIL rst_mid_beat2: tvalid=%b tdata=%h, expected 1 %h", M_AXIS_tvalid, M_AXIS_tdata, buf_q[2].d);
    end
    ARESET = 1'b1;
    M_AXIS_tready = 1'b0;
    step();
    tests++;
    if (M_AXIS_tvalid !== 1'b0 || BUSY !== 1'b0 || LOAD_READY !== 1'b0 || PKT_COUNT !== '0) begin
      fails++;
      $display("FAIL rst_mid_state: tvalid=%b busy=%b load_ready=%b pkt=%0d, expected 0 0 0 0",
               M_AXIS_tvalid, BUSY, LOAD_READY, PKT_COUNT);
    end
    ARESET = 1'b0;
    buf_q.delete();
    start_run(1, 0);
    capture(0, -1, 10, ds, us);
    tests++;
    if (ds != 1 || cap.size() != 0) begin
      fails++; $display("FAIL rst_mid_restart: done=%0d beats=%0d, expected 1 0", ds, cap.size());
    end
  endtask

  initial begin
    ARESET = 1'b1; LOAD_VALID = 1'b0; LOAD_DATA = '0; LOAD_KEEP = '0; LOAD_LAST = 1'b0;
    CLEAR = 1'b0; START = 1'b0; STOP = 1'b0; NUM_REPS = '0; GAP = '0; M_AXIS_tready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_gap();
    test_stop();
    test_random();
    test_full();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
